// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one single-port SRAM between the fetch and data ports.
// Data has priority; a starve counter forces a fetch grant after P_STARVE_MAX denials.
module unified_mem_arbiter #(
  parameter int P_DATA_WIDTH      = 32,
  parameter int P_ADDR_WIDTH      = 10,
  parameter int P_IMEM_ADDR_WIDTH = 9,
  parameter int P_DMEM_ADDR_WIDTH = 8,
  parameter int P_DMEM_BASE       = 'h200,
  parameter int P_STARVE_MAX      = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_if_req,
  input  logic [P_IMEM_ADDR_WIDTH-1:0] i_if_addr,
  output logic                         o_if_gnt,
  output logic                         o_if_rvalid,
  output logic [P_DATA_WIDTH-1:0]      o_if_rdata,
  input  logic                         i_d_req,
  input  logic                         i_d_we,
  input  logic [P_DMEM_ADDR_WIDTH-1:0] i_d_addr,
  input  logic [P_DATA_WIDTH-1:0]      i_d_wdata,
  output logic                         o_d_gnt,
  output logic                         o_d_rvalid,
  output logic [P_DATA_WIDTH-1:0]      o_d_rdata,
  output logic                         o_mem_en,
  output logic                         o_mem_we,
  output logic [P_ADDR_WIDTH-1:0]      o_mem_addr,
  output logic [P_DATA_WIDTH-1:0]      o_mem_wdata,
  input  logic [P_DATA_WIDTH-1:0]      i_mem_rdata
);
  localparam int SW = $clog2(P_STARVE_MAX + 1);
  localparam logic [P_ADDR_WIDTH-1:0] DMEM_BASE = P_ADDR_WIDTH'(P_DMEM_BASE);
  typedef enum logic [1:0] {IDLE, RESP_IF, RESP_D} state_t;
  state_t state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [P_DATA_WIDTH-1:0] if_rdata_q, if_rdata_d, d_rdata_q, d_rdata_d;
  logic starved;
  always_comb begin
    starved     = starve_q == SW'(P_STARVE_MAX);
    o_if_gnt    = ~i_rst & i_if_req & (~i_d_req | starved);
    o_d_gnt     = ~i_rst & i_d_req & ~o_if_gnt;
    o_mem_en    = o_if_gnt | o_d_gnt;
    o_mem_we    = o_d_gnt & i_d_we;
    o_mem_addr  = o_d_gnt ? DMEM_BASE + P_ADDR_WIDTH'(i_d_addr) :
                  o_if_gnt ? P_ADDR_WIDTH'(i_if_addr) : '0;
    o_mem_wdata = o_d_gnt ? i_d_wdata : '0;
    starve_d    = (~i_if_req | o_if_gnt) ? '0 : starved ? starve_q : starve_q + 1'b1;
    state_d     = o_if_gnt ? RESP_IF : (o_d_gnt & ~i_d_we) ? RESP_D : IDLE;
    o_if_rvalid = ~i_rst & (state_q == RESP_IF);
    o_d_rvalid  = ~i_rst & (state_q == RESP_D);
    // rdata passes the SRAM output through in the response cycle, then holds it
    if_rdata_d  = o_if_rvalid ? i_mem_rdata : if_rdata_q;
    d_rdata_d   = o_d_rvalid ? i_mem_rdata : d_rdata_q;
    o_if_rdata  = if_rdata_d;
    o_d_rdata   = d_rdata_d;
  end
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      starve_q   <= starve_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end
endmodule
